// File: rtl/riscv_ifu.sv
// riscv_ifu: single-outstanding instruction fetch unit.
// Fetches one word at a time, buffers it for decode and handles redirects.
module riscv_ifu #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [6:0]            opcode,
    output logic                  inst_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  kill_q, kill_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                  fault_q, fault_d;

    logic pc_ok;
    logic rd_misaligned;
    logic hs;

    assign pc_ok         = (pc_q[1:0] == 2'b00);
    assign rd_misaligned = (redirect_pc[1:0] != 2'b00);
    assign hs            = (state_q == S_REQ) && pc_ok && imem_req_ready;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            kill_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            kill_q    <= kill_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
        end
    end

    // Next-state logic; a redirect overrides every other event
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;
        // A killed response that shows up outside WAIT has been consumed
        if (imem_rsp_valid && (state_q == S_REQ || state_q == S_HOLD))
            kill_d = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc;
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (hs) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                S_HOLD: state_d = S_REQ;
                default: state_d = S_IDLE;
            endcase
            // Misaligned target: fault without touching memory
            if (rd_misaligned) begin
                state_d   = S_HOLD;
                inst_d    = '0;
                inst_pc_d = redirect_pc;
                fault_d   = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (!pc_ok) begin
                        state_d   = S_HOLD;
                        inst_d    = '0;
                        inst_pc_d = pc_q;
                        fault_d   = 1'b1;
                    end else if (imem_req_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            inst_d    = imem_rsp_data;
                            inst_pc_d = pc_q;
                            fault_d   = imem_rsp_err;
                            pc_d      = pc_q + ADDR_WIDTH'(4);
                            state_d   = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (inst_ready)
                        state_d = S_REQ;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        imem_req_valid = (state_q == S_REQ) && pc_ok;
        imem_req_addr  = imem_req_valid ? pc_q : '0;
        inst_valid     = (state_q == S_HOLD);
        opcode         = inst_valid ? inst_q[6:0] : 7'h00;
    end

    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = fault_q;

endmodule

// File: tb/tb_riscv_ifu.sv
// tb_riscv_ifu: directed scenarios plus a random run checked against
// a transaction-level model of the expected instruction stream.
module tb_riscv_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic        inst_fault;

    int n_chk  = 0;
    int n_fail = 0;

    riscv_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .opcode         (opcode),
        .inst_fault     (inst_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a[5:2] == 4'hF);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
        chk({tag, "_req_addr"},  64'(imem_req_addr),  64'd0);
        chk({tag, "_inst_valid"}, 64'(inst_valid),    64'd0);
        chk({tag, "_inst"},      64'(inst),           64'd0);
        chk({tag, "_inst_pc"},   64'(inst_pc),        64'd0);
        chk({tag, "_opcode"},    64'(opcode),         64'd0);
        chk({tag, "_fault"},     64'(inst_fault),     64'd0);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] h;
        logic [31:0] paddr;
        logic        pend;
        int          cnt;
        int          delivered;
        logic        rv;

        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outs("reset");

        // Basic fetch
        rst = 1'b0;
        step();
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr", 64'(imem_req_addr), 64'h8000_0000);
        imem_req_ready = 1'b1;
        step();
        chk("wait_no_req", 64'(imem_req_valid), 64'd0);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0093;
        step();
        imem_rsp_valid = 1'b0;
        chk("hold_valid", 64'(inst_valid), 64'd1);
        chk("hold_opcode", 64'(opcode), 64'h13);
        chk("hold_inst", 64'(inst), 64'h93);
        chk("hold_pc", 64'(inst_pc), 64'h8000_0000);
        chk("hold_fault", 64'(inst_fault), 64'd0);

        // Decode stall
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_inst", 64'(inst), 64'h93);
            chk("stall_pc", 64'(inst_pc), 64'h8000_0000);
            chk("stall_opcode", 64'(opcode), 64'h13);
            chk("stall_no_req", 64'(imem_req_valid), 64'd0);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("seq_req_addr", 64'(imem_req_addr), 64'h8000_0004);
        chk("seq_inst_invalid", 64'(inst_valid), 64'd0);
        chk("seq_opcode_zero", 64'(opcode), 64'd0);

        // Redirect while waiting; late response dropped
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("kill_wait_invalid", 64'(inst_valid), 64'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0033;
        step();
        imem_rsp_valid = 1'b0;
        chk("kill_drop_invalid", 64'(inst_valid), 64'd0);
        chk("kill_next_addr", 64'(imem_req_addr), 64'h8000_0100);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
        chk("mis_no_req", 64'(imem_req_valid), 64'd0);
        chk("mis_valid", 64'(inst_valid), 64'd1);
        chk("mis_fault", 64'(inst_fault), 64'd1);
        chk("mis_pc", 64'(inst_pc), 64'h8000_0102);
        chk("mis_inst", 64'(inst), 64'd0);

        // Fault and wrap at top of address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("top_req_addr", 64'(imem_req_addr), 64'hFFFF_FFFC);
        chk("top_hold_dropped", 64'(inst_valid), 64'd0);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        chk("err_fault", 64'(inst_fault), 64'd1);
        chk("err_pc", 64'(inst_pc), 64'hFFFF_FFFC);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("wrap_addr_valid", 64'(imem_req_valid), 64'd1);
        chk("wrap_addr", 64'(imem_req_addr), 64'h0);

        // Reset mid-transaction
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outs("async_rst");
        @(negedge clk);
        rst            = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        chk("post_rst_addr", 64'(imem_req_addr), 64'h8000_0000);
        chk("post_rst_invalid", 64'(inst_valid), 64'd0);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0033;
        step();
        imem_rsp_valid = 1'b0;
        chk("post_rst_inst", 64'(inst), 64'h33);
        chk("post_rst_pc", 64'(inst_pc), 64'h8000_0000);

        // Random run against the stream model
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        exp_pc    = 32'h8000_0000;
        pend      = 1'b0;
        paddr     = '0;
        cnt       = 0;
        delivered = 0;
        for (int c = 0; c < 1500; c++) begin
            step();
            if (imem_req_valid)
                chk("rnd_req_addr", 64'(imem_req_addr), 64'(exp_pc));
            if (inst_valid) begin
                h = mem_word(exp_pc);
                chk("rnd_inst_pc", 64'(inst_pc), 64'(exp_pc));
                chk("rnd_inst", 64'(inst), 64'(h));
                chk("rnd_opcode", 64'(opcode), 64'(h[6:0]));
                chk("rnd_fault", 64'(inst_fault), 64'(mem_err(exp_pc)));
            end else begin
                chk("rnd_opcode_idle", 64'(opcode), 64'd0);
            end
            imem_rsp_valid = 1'b0;
            imem_rsp_err   = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(paddr);
                    imem_rsp_err   = mem_err(paddr);
                    pend           = 1'b0;
                end else begin
                    cnt--;
                end
            end
            rv             = ($urandom_range(0, 11) == 0);
            redirect_valid = rv;
            redirect_pc    = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
            imem_req_ready = 1'($urandom_range(0, 1));
            inst_ready     = ($urandom_range(0, 2) != 0);
            if (imem_req_valid && imem_req_ready) begin
                pend  = 1'b1;
                paddr = imem_req_addr;
                cnt   = $urandom_range(0, 2);
            end
            if (rv) begin
                exp_pc = redirect_pc;
            end else if (inst_valid && inst_ready) begin
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
        end
        chk("rnd_progress", 64'(delivered > 50), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
